// File: rtl/full_adder.sv
// n-bit ripple-carry adder built from single-bit full-adder cells.
// Purely combinational; the carry chain runs LSB to MSB.
module full_adder #(
  parameter int unsigned n = 5
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         cin,
  output logic [n-1:0] sum,
  output logic         cout
);

  logic [n:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < n; i++) begin : g_cell
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[n];

endmodule

// File: rtl/add_accumulator.sv
// Block accumulator: adds COUNT accepted samples through one full_adder and
// presents the N-bit block sum with a sticky carry-out flag on a valid/ready port.
module add_accumulator #(
  parameter int unsigned N     = 5,
  parameter int unsigned COUNT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sum,
  output logic         out_ovf
);

  localparam int unsigned CNT_W = (COUNT < 2) ? 1 : $clog2(COUNT + 1);

  typedef enum logic {
    S_ACC  = 1'b0,
    S_DONE = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [N-1:0]     add_sum;
  logic             add_cout;
  logic [CNT_W-1:0] cnt_inc;

  // Sole arithmetic path: acc + in_data with no carry-in.
  full_adder #(
    .n (N)
  ) u_full_adder (
    .a    (acc_q),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign cnt_inc = CNT_W'(cnt_q + CNT_W'(1));

  // Next-state and datapath updates; clear outranks any handshake.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    if (clear) begin
      state_d = S_ACC;
      acc_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_ACC: begin
          if (in_valid) begin
            acc_d = add_sum;
            ovf_d = ovf_q | add_cout;
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(COUNT)) begin
              state_d = S_DONE;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_d = S_ACC;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = S_ACC;
        end
      endcase
    end

    // Handshake flags are registered copies of the next-state decode.
    in_ready_d  = (state_d == S_ACC);
    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_ACC;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;

endmodule

// File: doc/add_accumulator.md
# add_accumulator

Sequential accumulator that sits directly downstream of the team's `full_adder` ripple-carry adder and owns it. It accepts a stream of N-bit samples over a valid/ready handshake and adds each accepted sample into a registered running sum through one instance of `full_adder`. After COUNT samples it presents the N-bit block sum plus a sticky overflow flag on an output valid/ready handshake. It is the first clocked stage built around the combinational adder and turns it into a usable block-sum datapath.

## Interface
- N, default 5: sample and sum width; passed as `n` to the `full_adder` instance.
- COUNT, default 4: samples per block; legal range 1..255. The counter width is the minimum needed to hold COUNT.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- clear  input  1  synchronous abort of the current block; highest priority after reset.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  N  sample, unsigned.
- out_valid  output  1  out_sum and out_ovf hold a completed block result.
- out_ready  input  1  downstream accepts the result this cycle.
- out_sum  output  N  block sum modulo 2^N.
- out_ovf  output  1  set if any addition in the block produced carry-out.

## Operation
- Adder wiring:
  - a = acc register, b = in_data, cin = 1'b0.
  - sum goes to the acc D-input; cout is ORed into the ovf register.
  - No other arithmetic path exists.
- States: ACC (collecting samples) and DONE (holding the result).
- ACC state:
  - in_ready = 1, out_valid = 0.
  - Accept when in_valid & in_ready: acc <= acc + in_data (mod 2^N), ovf <= ovf | cout, cnt <= cnt + 1.
  - On the accept that makes cnt reach COUNT, go to DONE. cnt then stops counting.
  - When in_valid = 0, all registers hold.
- DONE state:
  - in_ready = 0, out_valid = 1; in_valid is ignored.
  - out_sum = acc and out_ovf = ovf, held stable until the handshake.
  - On out_valid & out_ready: acc, ovf and cnt clear to 0 and the next state is ACC.
- out_sum and out_ovf are driven directly from acc and ovf in every state. They are only meaningful while out_valid = 1.
- clear = 1 (synchronous) forces the next state to ACC and clears acc, ovf and cnt, in any state. It overrides a simultaneous input accept or output handshake, and a pending result is discarded.
- Reset (rst_n = 0, asynchronous):
  - state = ACC, acc = 0, ovf = 0, cnt = 0.
  - Resulting outputs: out_valid = 0, out_sum = 0, out_ovf = 0, in_ready = 1.
  - Any partial block is lost.
- COUNT = 1: every accepted sample produces a result of acc = in_data and ovf = 0.

## Timing
- in_ready and out_valid are decoded from registered state only, with no combinational path from in_valid or out_ready.
- Last sample accepted at edge t: out_valid = 1 from edge t+1, and out_sum already holds the final sum.
- Result accepted at edge u: in_ready = 1 from edge u+1. A new sample can be taken at u+1 at the earliest.
- With no stalls, a block takes COUNT + 1 cycles of throughput. The single DONE cycle is a mandatory bubble.
- The adder path is combinational from acc and in_data to the acc D-input, so one full N-bit ripple carry must fit in one clock period.

## Test plan
All scenarios use N = 5 and COUNT = 4.
- Basic block: feed 3, 5, 7, 9 back-to-back with out_ready = 1 -> out_valid for exactly 1 cycle, one cycle after 9 is accepted, with out_sum = 24 and out_ovf = 0. in_ready is 0 for that cycle only.
- Wrap and overflow: feed 31, 1, 0, 0 -> out_sum = 0, out_ovf = 1. The next block 1, 1, 1, 1 -> out_sum = 4, out_ovf = 0, confirming the flag clears.
- Backpressure: keep out_ready = 0 for 3 cycles after a result of 10 and toggle in_valid with data 7 -> out_valid, out_sum = 10 and in_ready = 0 all hold stable, and nothing is accepted. Then out_ready = 1 -> in_ready = 1 on the next cycle.
- Gapped input: feed 2, 4, 6, 8 with in_valid low on alternate cycles -> out_sum = 20. acc must be unchanged on every cycle where in_valid = 0.
- clear:
  - Pulse clear after accepting 10 and 10, in the same cycle that in_valid presents 5 -> the 5 is not added. Then feed 1, 2, 3, 4 -> out_sum = 10.
  - Pulse clear while in DONE with out_ready = 1 -> no handshake occurs, and out_valid = 0 next cycle.
- Reset mid-block: assert rst_n = 0 asynchronously between edges after 2 samples -> outputs read 0 / 0 / 0 with in_ready = 1 before the next edge. After release, 1, 1, 1, 1 -> out_sum = 4.
